// File: rtl/tt_um_jimktrains_vslc.sv
// VSLC: PLC-style 1-bit stack machine executing one instruction byte per clock.
// Top ties off the bidirectional pins; core wraps the executor that owns stack and coils.

module vslc_exec (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] instr,
  output logic [7:0] stack,
  output logic [7:0] coils
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_LDC  = 4'h2;
  localparam logic [3:0] OP_DROP = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_DUP  = 4'h8;
  localparam logic [3:0] OP_SWAP = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_SET  = 4'hB;
  localparam logic [3:0] OP_RST  = 4'hC;
  localparam logic [3:0] OP_STP  = 4'hD;

  logic [3:0] op;
  logic [3:0] arg;
  logic [2:0] n;
  logic       src;
  logic [7:0] stack_nx;
  logic [7:0] coils_nx;

  assign op  = instr[7:4];
  assign arg = instr[3:0];
  assign n   = arg[2:0];
  // Coil readback uses the registered coils, so a same-cycle write is not visible.
  assign src = arg[3] ? coils[n] : ui_in[n];

  always_comb begin
    stack_nx = stack;
    coils_nx = coils;
    case (op)
      OP_NOP:  ;
      OP_LD:   stack_nx = {stack[6:0], src};
      OP_LDC:  stack_nx = {stack[6:0], arg[0]};
      OP_DROP: stack_nx = {1'b0, stack[7:1]};
      OP_AND:  stack_nx = {1'b0, stack[7:2], stack[0] & stack[1]};
      OP_OR:   stack_nx = {1'b0, stack[7:2], stack[0] | stack[1]};
      OP_XOR:  stack_nx = {1'b0, stack[7:2], stack[0] ^ stack[1]};
      OP_NOT:  stack_nx = {stack[7:1], ~stack[0]};
      OP_DUP:  stack_nx = {stack[6:0], stack[0]};
      OP_SWAP: stack_nx = {stack[7:2], stack[0], stack[1]};
      OP_ST:   coils_nx[n] = stack[0];
      OP_SET:  if (stack[0]) coils_nx[n] = 1'b1;
      OP_RST:  if (stack[0]) coils_nx[n] = 1'b0;
      OP_STP: begin
        coils_nx[n] = stack[0];
        stack_nx    = {1'b0, stack[7:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stack <= 8'h00;
      coils <= 8'h00;
    end else if (ena) begin
      stack <= stack_nx;
      coils <= coils_nx;
    end
  end

endmodule

module vslc_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] instr,
  output logic [7:0] coils
);

  logic [7:0] stack;

  vslc_exec exec (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .ui_in (ui_in),
    .instr (instr),
    .stack (stack),
    .coils (coils)
  );

endmodule

module tt_um_jimktrains_vslc (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  vslc_core core (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .ui_in (ui_in),
    .instr (uio_in),
    .coils (uo_out)
  );

endmodule

// File: tb/tb_tt_um_jimktrains_vslc.sv
// Bench for the VSLC tile: directed test-plan sequence with literal expectations,
// then randomized instructions checked every cycle against a queue-based stack model.

module tb_tt_um_jimktrains_vslc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  // Model: stk[0] is top of stack, always exactly 8 entries; q holds coil bits.
  bit stk[$];
  bit q[8];

  tt_um_jimktrains_vslc dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_stack_byte();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = stk[i];
    return v;
  endfunction

  function automatic logic [7:0] m_coil_byte();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = q[i];
    return v;
  endfunction

  task automatic m_push(input bit b);
    stk.push_front(b);
    while (stk.size() > 8) void'(stk.pop_back());
  endtask

  task automatic m_pop();
    void'(stk.pop_front());
    stk.push_back(1'b0);
  endtask

  task automatic m_clear();
    stk.delete();
    for (int i = 0; i < 8; i++) stk.push_back(1'b0);
    for (int i = 0; i < 8; i++) q[i] = 1'b0;
  endtask

  task automatic m_exec(input logic [7:0] ins, input logic [7:0] ui, input bit en, input bit rs);
    int op, n;
    bit a3, a, b, src;
    op = ins[7:4];
    n  = ins[2:0];
    a3 = ins[3];
    if (rs) begin
      m_clear();
      return;
    end
    if (!en) return;
    src = a3 ? q[n] : ui[n];
    a = stk[0];
    b = stk[1];
    case (op)
      1: m_push(src);
      2: m_push(ins[0]);
      3: m_pop();
      4, 5, 6: begin
        m_pop();
        m_pop();
        m_push(op == 4 ? (a && b) : op == 5 ? (a || b) : (a != b));
      end
      7: stk[0] = !a;
      8: m_push(a);
      9: begin stk[0] = b; stk[1] = a; end
      10: q[n] = a;
      11: if (a) q[n] = 1'b1;
      12: if (a) q[n] = 1'b0;
      13: begin q[n] = a; m_pop(); end
      default: ;
    endcase
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectation applied both to the DUT and to the model.
  task automatic lit(input string name, input logic [7:0] stack_exp, input logic [7:0] coil_exp);
    check8({name, " stack"}, dut.core.exec.stack, stack_exp);
    check8({name, " uo_out"}, uo_out, coil_exp);
    check8({name, " model stack"}, m_stack_byte(), stack_exp);
    check8({name, " model coils"}, m_coil_byte(), coil_exp);
  endtask

  task automatic step(input logic [7:0] ins, input logic [7:0] ui, input bit en, input bit rs);
    @(negedge clk);
    uio_in = ins;
    ui_in  = ui;
    ena    = en;
    rst    = rs;
    @(posedge clk);
    m_exec(ins, ui, en, rs);
    #1;
  endtask

  task automatic run(input logic [7:0] ins);
    step(ins, ui_in, 1'b1, 1'b0);
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (checking) begin
      check8("cyc stack", dut.core.exec.stack, m_stack_byte());
      check8("cyc uo_out", uo_out, m_coil_byte());
      check8("cyc uio_oe", uio_oe, 8'h00);
      check8("cyc uio_out", uio_out, 8'h00);
    end
  end

  initial begin
    m_clear();
    step(8'h00, 8'h00, 1'b0, 1'b1);
    step(8'h00, 8'h00, 1'b0, 1'b1);
    checking = 1'b1;
    step(8'h00, 8'h00, 1'b1, 1'b0);
    lit("reset", 8'h00, 8'h00);
    check8("reset uio_oe", uio_oe, 8'h00);
    step(8'h21, 8'h00, 1'b0, 1'b0);
    lit("ena0 hold", 8'h00, 8'h00);

    ui_in = 8'h05;
    run(8'h10); lit("ld i0", 8'h01, 8'h00);
    run(8'h11); lit("ld i1", 8'h02, 8'h00);
    run(8'h50); lit("or", 8'h01, 8'h00);
    run(8'h70); lit("not", 8'h00, 8'h00);
    run(8'h11); run(8'h12);
    run(8'h40); lit("and", 8'h00, 8'h00);

    ui_in = 8'h80;
    run(8'h17); run(8'hA3); lit("st q3", 8'h01, 8'h08);
    run(8'h1B); lit("readback q3", 8'h03, 8'h08);
    run(8'hD3); lit("stp q3", 8'h01, 8'h08);

    run(8'h21); run(8'hB6); lit("set q6", 8'h03, 8'h48);
    run(8'h20); run(8'hC6); lit("rst tos0", 8'h06, 8'h48);
    run(8'h21); run(8'hC6); lit("rst q6", 8'h0D, 8'h08);

    for (int i = 0; i < 9; i++) run(8'h21);
    lit("overflow", 8'hFF, 8'h08);
    for (int i = 0; i < 9; i++) run(8'h30);
    lit("underflow", 8'h00, 8'h08);
    run(8'h21); run(8'h20); run(8'h90);
    lit("swap", 8'h01, 8'h08);

    for (int i = 0; i < 8; i++) run(8'h21);
    for (int i = 0; i < 8; i++) run(8'hA0 | 8'(i));
    lit("all ones", 8'hFF, 8'hFF);
    step(8'h21, ui_in, 1'b1, 1'b1);
    lit("reset mid-op", 8'h00, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      step(8'($urandom), 8'($urandom), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 199) == 0));
    end

    @(negedge clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_jimktrains_vslc.md
Name: tt_um_jimktrains_vslc

Overview:
- VSLC (very simple logic controller): a PLC-style 1-bit stack machine in a Tiny Tapeout user tile.
- Executes one 8-bit instruction per clock, presented on uio_in, while ena is high.
- Reads 8 digital inputs (ui_in) and drives 8 latched output coils (uo_out).
- Logic is evaluated on an 8-deep bit stack.
- Hierarchy: top instantiates `core`, which instantiates `exec`. `exec` holds the stack register `stack[7:0]`; stack[0] = TOS, stack[1] = NOS, stack[2] = HOS. Verification probes core.exec.stack by hierarchical path.

Parameters:
None (fixed: stack depth 8, 8 inputs, 8 outputs).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- ena  input  1  execute enable; when 0 all state holds.
- ui_in  input  8  digital inputs I0..I7.
- uo_out  output  8  output coil register Q0..Q7.
- uio_in  input  8  instruction byte: op = [7:4], arg = [3:0].
- uio_out  output  8  tied 0.
- uio_oe  output  8  tied 0 (all uio pins are inputs).

Behaviour:
- One clock, synchronous active-high reset. On a reset cycle: stack = 8'h00, uo_out = 8'h00. Reset has priority over ena and over the instruction.
- Decode and execute take one cycle. The result is visible in stack/uo_out right after the edge that sampled the instruction. No pipeline, no handshake.
- ena = 0: stack and uo_out hold; the instruction is ignored.
- push(b): stack <= {stack[6:0], b}. The old stack[7] is discarded (overflow silently drops the bottom).
- pop: stack <= {1'b0, stack[7:1]}. Underflow reads 0.
- Binary op r = f(TOS, NOS): stack <= {1'b0, stack[7:2], r}.
- Source select, n = arg[2:0]: arg[3] = 0 selects ui_in[n]; arg[3] = 1 selects uo_out[n] (coil readback).
- Opcodes:
  - 0x0 NOP.
  - 0x1 LD: push(source).
  - 0x2 LDC: push(arg[0]).
  - 0x3 DROP: pop.
  - 0x4 AND, 0x5 OR, 0x6 XOR: binary ops.
  - 0x7 NOT: stack[0] <= ~stack[0].
  - 0x8 DUP: push(stack[0]).
  - 0x9 SWAP: exchange stack[0] and stack[1].
  - 0xA ST: uo_out[n] <= stack[0]; stack unchanged.
  - 0xB SET: if stack[0], then uo_out[n] <= 1.
  - 0xC RST: if stack[0], then uo_out[n] <= 0.
  - 0xD STP: uo_out[n] <= stack[0], then pop.
  - 0xE, 0xF: NOP (reserved).
- For ST, SET, RST and STP, arg[3] is ignored.
- Reads of ui_in are combinational in the executing cycle; there is no synchronizer inside the block.
- Coil readback during the same cycle as a coil write sees the pre-edge value.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then uio_in=0x00 -> stack=0x00, uo_out=0x00, uio_oe=0x00; ena=0 with uio_in=0x21 -> stack stays 0x00.
- Load/logic: ui_in=0x05; exec 0x10, 0x11, 0x50 -> stack after each = 0x01, 0x02, 0x01. Then 0x70 -> stack[0]=0. Then 0x11, 0x12, 0x40 -> stack[0]=0.
- Store: ui_in=0x80; exec 0x17, 0xA3 -> uo_out=0x08. Exec 0x1B (readback Q3) -> stack[0]=1. Exec 0xD3 -> pop, uo_out bit3 stays 1.
- Set/reset latch: push 1 (0x21), exec 0xB6 -> uo_out[6]=1. Exec 0x20, 0xC6 -> unchanged (TOS=0). Exec 0x21, 0xC6 -> uo_out[6]=0.
- Stack boundaries: 9x 0x21 -> stack=0xFF (the first push is dropped off the bottom). 9x 0x30 -> stack=0x00 (underflow fills 0). Exec 0x21, 0x20, 0x90 -> stack[1:0]=2'b01 after SWAP.
- Reset mid-operation: with stack=0xFF and uo_out=0xFF, assert rst together with 0x21 -> next cycle stack=0x00, uo_out=0x00.
